// File: rtl/prog_bus_pkg.sv
// Shared definitions for the Tiny DSP program-bus controller: state encoding,
// default parameter values and a small width helper.
package prog_bus_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int BL_W_DEF    = 2;
  localparam int WAIT_RD_DEF = 0;
  localparam int WAIT_WR_DEF = 0;
  localparam int TO_W_DEF    = 4;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_CAP  = 3'd3,
    S_WR_ASRT = 3'd4,
    S_WR_HOLD = 3'd5,
    S_WR_DEAS = 3'd6,
    S_CLEAR   = 3'd7
  } state_e;

  // Smallest counter width able to hold max_val (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((2 ** w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/prog_bus_cnt.sv
// Loadable saturating down-counter with a terminal (zero) flag; used for the
// wait-state and timeout counts of the program-bus controller.
module prog_bus_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prog_bus_ctrl.sv
// Program-bus controller: turns a core go request into single or burst
// read/write cycles on the program-memory pads, with wait states and timeout.
module prog_bus_ctrl
  import prog_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BL_W    = BL_W_DEF,
  parameter int WAIT_RD = WAIT_RD_DEF,
  parameter int WAIT_WR = WAIT_WR_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              read_cycle,
  input  logic [BL_W-1:0]   burst_len,
  input  logic [ADDR_W-1:0] addrs_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_req,
  input  logic [DATA_W-1:0] pad_data_in,
  input  logic              pad_rdy,
  output logic [DATA_W-1:0] pad_data_out,
  output logic [ADDR_W-1:0] address,
  output logic              as,
  output logic              read,
  output logic              write,
  output logic              write_h,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WAIT_W = cnt_width((WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR);

  state_e            state_q;
  logic              rd_q;
  logic [BL_W-1:0]   len_q;
  logic [BL_W-1:0]   beat_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] pad_data_out_q;
  logic [DATA_W-1:0] data_out_q;
  logic              as_q, read_q, write_q, write_h_q;
  logic              rd_valid_q, busy_q, done_q, err_q, wr_data_req_q;

  logic              last_beat, in_wait, wait_zero, to_zero;
  logic              ready, stall, timeout, cnt_load;
  logic [WAIT_W-1:0] wait_load_val;

  assign last_beat     = (beat_q == len_q);
  assign in_wait       = (state_q == S_RD_WAIT) || (state_q == S_WR_ASRT);
  assign ready         = in_wait && wait_zero && pad_rdy;
  assign stall         = in_wait && wait_zero && !pad_rdy;
  assign timeout       = stall && to_zero;
  // Both counters are reloaded on every edge that enters a wait-capable state.
  assign cnt_load      = (state_q == S_ADDR) ||
                         ((state_q == S_RD_CAP || state_q == S_WR_DEAS) && !last_beat);
  assign wait_load_val = rd_q ? WAIT_W'(WAIT_RD) : WAIT_W'(WAIT_WR);

  prog_bus_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (cnt_load),
    .load_val_i (wait_load_val),
    .dec_i      (in_wait),
    .zero_o     (wait_zero)
  );

  // Loaded with limit-1 so the abort fires on the (2**TO_W-1)th stall cycle.
  prog_bus_cnt #(.W(TO_W)) u_to_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (cnt_load),
    .load_val_i (TO_W'(2 ** TO_W - 2)),
    .dec_i      (stall),
    .zero_o     (to_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rd_q           <= 1'b0;
      len_q          <= '0;
      beat_q         <= '0;
      wdata_q        <= '0;
      address_q      <= '0;
      pad_data_out_q <= '0;
      data_out_q     <= '0;
      as_q           <= 1'b0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      write_h_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      wr_data_req_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later <= in the case wins, so each
      // pulse output lasts exactly the one cycle a branch asserts it.
      rd_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_data_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            rd_q      <= read_cycle;
            len_q     <= burst_len;
            beat_q    <= '0;
            address_q <= addrs_in;
            wdata_q   <= wr_data;
            as_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rd_q) begin
            read_q  <= 1'b1;
            state_q <= S_RD_WAIT;
          end else begin
            write_q        <= 1'b1;
            write_h_q      <= 1'b1;
            pad_data_out_q <= wdata_q;
            state_q        <= S_WR_ASRT;
          end
        end
        S_RD_WAIT: begin
          if (ready) begin
            read_q     <= 1'b0;
            data_out_q <= pad_data_in;
            rd_valid_q <= 1'b1;
            state_q    <= S_RD_CAP;
          end else if (timeout) begin
            read_q  <= 1'b0;
            as_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_RD_CAP: begin
          if (last_beat) begin
            as_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_CLEAR;
          end else begin
            beat_q    <= beat_q + 1'b1;
            address_q <= address_q + 1'b1;
            read_q    <= 1'b1;
            state_q   <= S_RD_WAIT;
          end
        end
        S_WR_ASRT: begin
          if (ready) begin
            write_q <= 1'b0;
            state_q <= S_WR_HOLD;
          end else if (timeout) begin
            write_q   <= 1'b0;
            write_h_q <= 1'b0;
            as_q      <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end
        S_WR_HOLD: begin
          write_h_q     <= 1'b0;
          wr_data_req_q <= !last_beat;
          state_q       <= S_WR_DEAS;
        end
        S_WR_DEAS: begin
          if (last_beat) begin
            as_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_CLEAR;
          end else begin
            // The requester answered wr_data_req during this cycle.
            beat_q         <= beat_q + 1'b1;
            address_q      <= address_q + 1'b1;
            pad_data_out_q <= wr_data;
            write_q        <= 1'b1;
            write_h_q      <= 1'b1;
            state_q        <= S_WR_ASRT;
          end
        end
        S_CLEAR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_data_req  = wr_data_req_q;
  assign pad_data_out = pad_data_out_q;
  assign address      = address_q;
  assign as           = as_q;
  assign read         = read_q;
  assign write        = write_q;
  assign write_h      = write_h_q;
  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: doc/prog_bus_ctrl.md
# prog_bus_ctrl

Parametrised program-bus controller for the Tiny DSP; successor to the fixed-width single-beat program bus machine. Converts a core-side `go` request into read or write cycles on the program-memory pad bus. Adds configurable address/data width, programmable wait states, `pad_rdy` stretching with timeout, and incrementing bursts of up to `2**BL_W` beats. Sits between the fetch/table-access logic and the program-memory pads.

## Interface
- `ADDR_W`, 12: program address width.
- `DATA_W`, 16: data width.
- `BL_W`, 2: burst-length field width; beats = `burst_len`+1.
- `WAIT_RD`, 0: extra read wait cycles before `pad_rdy` is sampled.
- `WAIT_WR`, 0: extra cycles `write` stays asserted.
- `TO_W`, 4: timeout counter width; timeout after `2**TO_W-1` cycles of `pad_rdy`=0.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request, sampled in IDLE only.
- `read_cycle`  in  1  1 = read, 0 = write; latched with `go`.
- `burst_len`  in  BL_W  beats-1; latched with `go`.
- `addrs_in`  in  ADDR_W  base address; latched with `go`.
- `wr_data`  in  DATA_W  write data for current beat.
- `wr_data_req`  out  1  one-cycle pulse: present next beat's `wr_data` on the following cycle.
- `pad_data_in`  in  DATA_W  pad read data.
- `pad_rdy`  in  1  memory ready.
- `pad_data_out`  out  DATA_W  pad write data.
- `address`  out  ADDR_W  pad address.
- `as`, `read`, `write`, `write_h`  out  1  address strobe, read enable, write enable, write hold.
- `data_out`  out  DATA_W  captured read data.
- `rd_valid`  out  1  one-cycle pulse, `data_out` valid.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse, transfer complete.
- `err`  out  1  one-cycle pulse with `done` on timeout.

## Operation
- All outputs registered; reset value 0 for every output; state IDLE; counters 0.
- States: IDLE, ADDR, RD_WAIT, RD_CAP, WR_ASRT, WR_HOLD, WR_DEAS, CLEAR.
- IDLE: on `go`=1 latch `addrs_in`, `read_cycle`, `burst_len`, `wr_data`; beat=0 → ADDR. `go` while busy ignored.
- ADDR: `as`=1, `address`=base → RD_WAIT if read else WR_ASRT.
- RD_WAIT: `as`=`read`=1; wait counter runs WAIT_RD cycles, then stay until `pad_rdy`=1 → RD_CAP.
- RD_CAP: `as`=1, `data_out`<=`pad_data_in`, `rd_valid`=1 → RD_WAIT for next beat (address+1) or CLEAR on last beat.
- WR_ASRT: `as`=`write`=`write_h`=1, `pad_data_out`=latched data; hold ≥1+WAIT_WR cycles and until `pad_rdy`=1 → WR_HOLD.
- WR_HOLD: `as`=`write_h`=1, `write`=0 → WR_DEAS.
- WR_DEAS: `as`=1 only; if more beats: `wr_data_req`=1, latch `wr_data` next cycle, address+1 → WR_ASRT; else CLEAR.
- CLEAR: `as`=0, `done`=1 → IDLE.
- Address = base + beat, modulo `2**ADDR_W` (wraps, no error).
- Timeout: in RD_WAIT/WR_ASRT, counter increments while `pad_rdy`=0 after wait states; at saturation abort: drop `read`/`write`, → CLEAR with `err`=1. Remaining beats discarded; no `rd_valid`.
- `reset_n` low mid-transfer: immediate return to IDLE, all outputs 0, no `done`.

## Timing
- Single read, WAIT_RD=0, `pad_rdy`=1: `go` sampled edge 0; ADDR cycle 1, RD_WAIT 2, RD_CAP 3 (`rd_valid`), CLEAR 4 (`done`). Latency 4 cycles go→done.
- Each burst read beat after the first: 2 cycles (+WAIT_RD, +ready stall).
- Single write, WAIT_WR=0: ADDR 1, WR_ASRT 2, WR_HOLD 3, WR_DEAS 4, CLEAR 5 (`done`); each further beat 3 cycles.
- `go` accepted again in the IDLE cycle following CLEAR.

## Structure
- Shared package `prog_bus_pkg`: state encoding constants (3-bit), default parameter values.
- One sub-module natural: `prog_bus_cnt` — loadable wait/timeout down-counter with terminal flag, instanced for wait states and timeout.

## Test plan
- Read, base 0x010, burst_len 0, `pad_data_in`=0xA5A5 → `rd_valid` cycle 3, `data_out`=0xA5A5, `done` cycle 4, `err`=0.
- Read burst_len 3, base 0xFFE (ADDR_W 12) → addresses 0xFFE, 0xFFF, 0x000, 0x001, four `rd_valid` pulses, one `done`.
- Write burst_len 1, WAIT_WR=2, data 0x1234 then 0x5678 → `write` high 3 cycles per beat, `write_h` one cycle longer, one `wr_data_req`, `done` once.
- Read with `pad_rdy` held 0 → after 15 stall cycles (TO_W 4) `read` drops, `done`=`err`=1 same cycle, no `rd_valid`.
- `reset_n` low during WR_ASRT → all outputs 0 asynchronously; after release `go` starts a fresh transfer normally.
- `go` pulsed while busy → ignored; exactly one `done`.
